// File: rtl/vc32_mem_pkg.sv
// Shared definitions for the cache <-> quad memory bus line-transfer path.
//   state_e       : controller FSM states
//   CMD_READ/WRITE: bus opcodes sent in the CMD phase
//   ADDR_NIBBLES  : number of address nibbles framed after the opcode
package vc32_mem_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CMD       = 4'd1,
    ST_ADDR      = 4'd2,
    ST_WDATA     = 4'd3,
    ST_DUMMY     = 4'd4,
    ST_RDATA     = 4'd5,
    ST_FILL_LAST = 4'd6,
    ST_GAP       = 4'd7,
    ST_DONE      = 4'd8
  } state_e;

  localparam logic [7:0] CMD_READ     = 8'hEB;
  localparam logic [7:0] CMD_WRITE    = 8'h38;
  localparam int         CMD_NIBBLES  = 2;
  localparam int         ADDR_NIBBLES = 6;

endpackage

// File: rtl/nibble_shifter.sv
// Loadable 32-bit shift register that presents its top nibble every cycle.
// Used to frame the 2 opcode nibbles followed by the 6 address nibbles.
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : load data_i (has priority over shift_i)
//   shift_i        : shift left by one nibble, zero fill
//   data_i         : {opcode, 24-bit address}
//   nib_o          : current top nibble
module nibble_shifter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic        shift_i,
  input  logic [31:0] data_i,
  output logic [3:0]  nib_o
);

  logic [31:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = {sr_q[27:0], 4'h0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // After all eight nibbles are shifted out the register holds zero, so the
  // bus idles at 0 outside the command/address phases.
  assign nib_o = sr_q[31:28];

endmodule

// File: rtl/dcache_mem.sv
// Line-transfer controller between the data cache and the nibble-wide memory
// bus. A miss request runs an optional dirty-line writeback (push) and then an
// optional line fill (pull); the core stalls on busy meanwhile.
//   clk, reset           : clock, synchronous active-high reset
//   req_push, req_pull   : transfer requests, sampled in IDLE only
//   wb_tag, fill_tag     : victim / fill line addresses, latched at accept
//   dwrite, rstrobe_d    : victim nibble from cache / consume-and-advance
//   dread, wstrobe_d     : fill nibble to cache / write-and-advance
//   busy, done           : transfer in progress / one-cycle completion pulse
//   mem_cs_n, mem_dout,
//   mem_doe, mem_din     : quad memory bus
//   dbg_state            : current FSM state, for observation only
//
// Request handshake: a request is a level. The requester raises req_push
// and/or req_pull with stable tags and holds them; the controller samples them
// only in IDLE (that edge is the acceptance), ignores them while busy, and
// pulses done once after the last phase. The requester may drop or re-raise
// the request in the done cycle; a still-high request starts a new transfer
// from the following IDLE cycle.
module dcache_mem
  import vc32_mem_pkg::*;
#(
  parameter int LINE_LENGTH  = 4,
  parameter int PA           = 22,
  parameter int DUMMY_CYCLES = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req_push,
  input  logic                                req_pull,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   wb_tag,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   fill_tag,
  input  logic [3:0]                          dwrite,
  output logic                                rstrobe_d,
  output logic [3:0]                          dread,
  output logic                                wstrobe_d,
  output logic                                busy,
  output logic                                done,
  output logic                                mem_cs_n,
  output logic [3:0]                          mem_dout,
  output logic                                mem_doe,
  input  logic [3:0]                          mem_din,
  output state_e                              dbg_state
);

  localparam int OFS_W        = $clog2(LINE_LENGTH);
  localparam int TAG_W        = PA - OFS_W;
  localparam int DATA_NIBBLES = 2 * LINE_LENGTH;

  // Phase counter reload values: each phase counts down to zero.
  localparam logic [4:0] CNT_CMD   = 5'(CMD_NIBBLES - 1);
  localparam logic [4:0] CNT_ADDR  = 5'(ADDR_NIBBLES - 1);
  localparam logic [4:0] CNT_DATA  = 5'(DATA_NIBBLES - 1);
  // The last turnaround cycle already carries read nibble 0 and is the first
  // RDATA capture cycle, so the DUMMY state itself is one shorter.
  localparam logic [4:0] CNT_DUMMY = 5'(DUMMY_CYCLES - 2);

  function automatic logic [23:0] line_addr(input logic [TAG_W-1:0] tag);
    logic [PA-1:0] pa;
    pa = {tag, {OFS_W{1'b0}}};
    return 24'(pa);
  endfunction

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             wr_phase_q, wr_phase_d;
  logic             pull_q, pull_d;
  logic [TAG_W-1:0] wb_tag_q, wb_tag_d;
  logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
  logic [3:0]       wdata_q;
  logic [3:0]       dread_q;
  logic             wstrobe_q;

  logic             sh_load, sh_shift;
  logic [31:0]      sh_data;
  logic [3:0]       sh_nib;

  nibble_shifter u_shifter (
    .clk_i   (clk),
    .reset_i (reset),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .data_i  (sh_data),
    .nib_o   (sh_nib)
  );

  // Next-state logic. The shifter is loaded on the edge that enters CMD so
  // the first opcode nibble is on the bus for the whole first CMD cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_phase_d = wr_phase_q;
    pull_d     = pull_q;
    wb_tag_d   = wb_tag_q;
    fill_tag_d = fill_tag_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_data    = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_push || req_pull) begin
          state_d    = ST_CMD;
          cnt_d      = CNT_CMD;
          wr_phase_d = req_push;
          pull_d     = req_pull;
          wb_tag_d   = wb_tag;
          fill_tag_d = fill_tag;
          sh_load    = 1'b1;
          sh_data    = req_push ? {CMD_WRITE, line_addr(wb_tag)}
                                : {CMD_READ, line_addr(fill_tag)};
        end
      end
      ST_CMD: begin
        sh_shift = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = ST_ADDR;
          cnt_d   = CNT_ADDR;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_ADDR: begin
        sh_shift = 1'b1;
        if (cnt_q == 5'd0) begin
          state_d = wr_phase_q ? ST_WDATA : ST_DUMMY;
          cnt_d   = wr_phase_q ? CNT_DATA : CNT_DUMMY;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_WDATA: begin
        if (cnt_q == 5'd0) begin
          state_d = pull_q ? ST_GAP : ST_DONE;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_GAP: begin
        state_d    = ST_CMD;
        cnt_d      = CNT_CMD;
        wr_phase_d = 1'b0;
        sh_load    = 1'b1;
        sh_data    = {CMD_READ, line_addr(fill_tag_q)};
      end
      ST_DUMMY: begin
        if (cnt_q == 5'd0) begin
          state_d = ST_RDATA;
          cnt_d   = CNT_DATA;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_RDATA: begin
        if (cnt_q == 5'd0) begin
          state_d = ST_FILL_LAST;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      ST_FILL_LAST: state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_phase_q <= 1'b0;
      pull_q     <= 1'b0;
      wb_tag_q   <= '0;
      fill_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_phase_q <= wr_phase_d;
      pull_q     <= pull_d;
      wb_tag_q   <= wb_tag_d;
      fill_tag_q <= fill_tag_d;
    end
  end

  // Victim read strobes lead the bus by one cycle: the nibble consumed in the
  // last ADDR cycle is on mem_dout during the first WDATA cycle.
  assign rstrobe_d = wr_phase_q &&
                     (((state_q == ST_ADDR) && (cnt_q == 5'd0)) ||
                      ((state_q == ST_WDATA) && (cnt_q != 5'd0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdata_q   <= '0;
      dread_q   <= '0;
      wstrobe_q <= 1'b0;
    end else begin
      if (rstrobe_d) begin
        wdata_q <= dwrite;
      end
      if (state_q == ST_RDATA) begin
        dread_q <= mem_din;
      end
      // One fill strobe per RDATA capture; the last one lands in FILL_LAST.
      wstrobe_q <= (state_q == ST_RDATA);
    end
  end

  assign dread     = dread_q;
  assign wstrobe_d = wstrobe_q;
  assign mem_dout  = (state_q == ST_WDATA) ? wdata_q : sh_nib;
  assign mem_doe   = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                     (state_q == ST_WDATA);
  assign mem_cs_n  = !((state_q == ST_CMD)   || (state_q == ST_ADDR)  ||
                       (state_q == ST_WDATA) || (state_q == ST_DUMMY) ||
                       (state_q == ST_RDATA) || (state_q == ST_FILL_LAST));
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcache_mem.sv
module tb_dcache_mem;
  import vc32_mem_pkg::*;

  localparam int TW = 20;
  localparam int NN = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          req_push, req_pull;
  logic [TW-1:0] wb_tag, fill_tag;
  logic [3:0]    dwrite;
  logic          rstrobe_d;
  logic [3:0]    dread;
  logic          wstrobe_d;
  logic          busy, done;
  logic          mem_cs_n;
  logic [3:0]    mem_dout;
  logic          mem_doe;
  logic [3:0]    mem_din;
  state_e        dbg_state;

  always #5 clk = ~clk;

  dcache_mem #(.LINE_LENGTH(4), .PA(22), .DUMMY_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_push  (req_push),
    .req_pull  (req_pull),
    .wb_tag    (wb_tag),
    .fill_tag  (fill_tag),
    .dwrite    (dwrite),
    .rstrobe_d (rstrobe_d),
    .dread     (dread),
    .wstrobe_d (wstrobe_d),
    .busy      (busy),
    .done      (done),
    .mem_cs_n  (mem_cs_n),
    .mem_dout  (mem_dout),
    .mem_doe   (mem_doe),
    .mem_din   (mem_din),
    .dbg_state (dbg_state)
  );

  // ---------------- cache side model ----------------
  // Offsets advance on a strobe and fall back to 0 whenever it is absent.
  logic [3:0] vict[NN];
  logic [3:0] line[NN];
  logic [3:0] rd[NN];
  logic [2:0] roff = 3'd0;
  logic [2:0] woff = 3'd0;

  assign dwrite = vict[roff];

  always @(posedge clk) begin
    roff <= rstrobe_d ? roff + 3'd1 : 3'd0;
    woff <= wstrobe_d ? woff + 3'd1 : 3'd0;
    if (wstrobe_d) line[woff] <= dread;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] bus_nib(input logic [7:0] cmd,
                                         input logic [TW-1:0] tag,
                                         input int j);
    logic [31:0] w;
    w = {cmd, 2'b00, tag, 2'b00};
    return w[31-4*j -: 4];
  endfunction

  // Expected per-cycle bus/strobe picture, cycle k counted from the
  // acceptance edge (k=1 is the first cycle after it).
  // Packing: {busy, done, cs_n, doe, rstrobe, wstrobe, dout-if-driven}.
  task automatic build_exp(input bit push, input bit pull,
                           input logic [TW-1:0] wb, input logic [TW-1:0] fill,
                           output int end_k, output int rs);
    logic b, dn, cs_n, doe, rstb, wstb;
    logic [3:0] dout;
    int j;
    rs    = push ? 18 : 1;
    end_k = pull ? rs + 20 : 17;
    for (int k = 1; k <= end_k + 1; k++) begin
      b = (k < end_k); dn = (k == end_k);
      cs_n = 1'b1; doe = 1'b0; rstb = 1'b0; wstb = 1'b0; dout = 4'h0;
      if (push && k >= 1 && k <= 16) begin
        j = k - 1;
        cs_n = 1'b0; doe = 1'b1;
        dout = (j < 8) ? bus_nib(8'h38, wb, j) : vict[j-8];
        rstb = (k >= 8) && (k <= 15);
      end
      if (pull && k >= rs && k <= rs + 19) begin
        j = k - rs;
        cs_n = 1'b0;
        doe  = (j < 8);
        dout = (j < 8) ? bus_nib(8'hEB, fill, j) : 4'h0;
        wstb = (j >= 12);
      end
      exp_q.push_back({b, dn, cs_n, doe, rstb, wstb, dout});
    end
  endtask

  function automatic logic [9:0] observe();
    return {busy, done, mem_cs_n, mem_doe, rstrobe_d, wstrobe_d,
            mem_doe ? mem_dout : 4'h0};
  endfunction

  // Memory device: read nibble i is presented in read cycle rs+11+i.
  task automatic drive_mem(input bit pull, input int rs, input int k);
    if (pull && k >= rs + 11 && k <= rs + 18) mem_din = rd[k-rs-11];
    else mem_din = 4'($urandom_range(15, 0));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge in an IDLE cycle; returns at the negedge of the
  // IDLE cycle that follows done.
  task automatic run_txn(input string name, input bit push, input bit pull,
                         input logic [TW-1:0] wb, input logic [TW-1:0] fill,
                         input bit scramble, input bit hold);
    int end_k, rs, nr, nw;
    nr = 0; nw = 0;
    req_push = push; req_pull = pull; wb_tag = wb; fill_tag = fill;
    build_exp(push, pull, wb, fill, end_k, rs);
    for (int k = 1; k <= end_k + 1; k++) begin
      @(negedge clk);
      drive_mem(pull, rs, k);
      if (scramble && k < end_k && (k % 5) == 0) begin
        req_push = 1'($urandom_range(1, 0));
        req_pull = 1'($urandom_range(1, 0));
        wb_tag   = TW'($urandom);
        fill_tag = TW'($urandom);
      end
      if (k == end_k && !hold) begin
        req_push = 1'b0; req_pull = 1'b0;
      end
      check($sformatf("%s k%0d", name, k), 32'(observe()), 32'(exp_q.pop_front()));
      nr += int'(rstrobe_d);
      nw += int'(wstrobe_d);
    end
    check({name, " rstb_cnt"}, nr, push ? 8 : 0);
    check({name, " wstb_cnt"}, nw, pull ? 8 : 0);
    if (pull) begin
      for (int i = 0; i < NN; i++)
        check($sformatf("%s line%0d", name, i), 32'(line[i]), 32'(rd[i]));
    end
  endtask

  task automatic idle(input int n);
    req_push = 1'b0; req_pull = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_din = 4'($urandom_range(15, 0));
      check("idle", {busy, mem_cs_n, rstrobe_d, wstrobe_d}, 4'b0100);
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < NN; i++) begin
      vict[i] = 4'($urandom_range(15, 0));
      rd[i]   = 4'($urandom_range(15, 0));
    end
  endtask

  task automatic reset_mid_pull(input logic [TW-1:0] fill);
    int end_k, rs;
    req_push = 1'b0; req_pull = 1'b1; fill_tag = fill; wb_tag = '0;
    build_exp(1'b0, 1'b1, '0, fill, end_k, rs);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      drive_mem(1'b1, rs, k);
      check($sformatf("rstmid k%0d", k), 32'(observe()), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    reset = 1'b1;            // sampled while nibble 3 is being captured
    @(negedge clk);
    check("rstmid cs_n",  mem_cs_n, 1);
    check("rstmid strb",  {rstrobe_d, wstrobe_d}, 0);
    check("rstmid busy",  {busy, done, mem_doe}, 0);
    check("rstmid dread", dread, 0);
    reset = 1'b0; req_pull = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [TW-1:0] wb, fl;
    bit p, q;
    reset = 1'b1; req_push = 1'b0; req_pull = 1'b0;
    wb_tag = '0; fill_tag = '0; mem_din = 4'h0;
    for (int i = 0; i < NN; i++) begin vict[i] = 4'h0; rd[i] = 4'h0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst cs_n",  mem_cs_n, 1);
    check("rst doe",   mem_doe, 0);
    check("rst dout",  mem_dout, 0);
    check("rst strb",  {rstrobe_d, wstrobe_d}, 0);
    check("rst dread", dread, 0);
    check("rst busy",  busy, 0);
    check("rst done",  done, 0);
    reset = 1'b0;
    idle(2);

    // Pull only, known tag and data 0..7.
    for (int i = 0; i < NN; i++) rd[i] = 4'(i);
    run_txn("pull", 1'b0, 1'b1, 20'h0, 20'h12345, 1'b0, 1'b0);
    idle(1);

    // Push only, victim nibble k = 15-k.
    for (int i = 0; i < NN; i++) vict[i] = 4'(15 - i);
    run_txn("push", 1'b1, 1'b0, 20'h00001, 20'h0, 1'b0, 1'b0);
    idle(2);

    // Push then pull.
    rand_data();
    run_txn("pushpull", 1'b1, 1'b1, 20'hABCDE, 20'h54321, 1'b0, 1'b0);
    idle(1);

    // Reset during read data, then a clean pull.
    rand_data();
    reset_mid_pull(20'h0F0F0);
    idle(2);
    rand_data();
    run_txn("postrst", 1'b0, 1'b1, 20'h0, 20'h0BEEF, 1'b0, 1'b0);

    // Request and tag inputs disturbed while busy.
    rand_data();
    run_txn("scramble", 1'b1, 1'b1, 20'h13579, 20'h2468A, 1'b1, 1'b0);
    idle(1);

    // Back-to-back with the request held through done.
    rand_data();
    run_txn("b2b0", 1'b0, 1'b1, 20'h0, 20'h11111, 1'b0, 1'b1);
    rand_data();
    run_txn("b2b1", 1'b1, 1'b0, 20'h22222, 20'h0, 1'b0, 1'b1);
    rand_data();
    run_txn("b2b2", 1'b1, 1'b1, 20'h33333, 20'h44444, 1'b0, 1'b0);
    idle(1);

    // Randomized transfers.
    for (int n = 0; n < 10; n++) begin
      p = 1'($urandom_range(1, 0));
      q = p ? 1'($urandom_range(1, 0)) : 1'b1;
      wb = TW'($urandom);
      fl = TW'($urandom);
      rand_data();
      run_txn($sformatf("rnd%0d", n), p, q, wb, fl, 1'($urandom_range(1, 0)), 1'b0);
      idle($urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
